// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle ops are registered one edge after accept, and MUL is a WIDTH-iteration radix-2 Booth multiply.
// No output backpressure: out_valid is a 1-cycle pulse, and in_ready drops for the WIDTH cycles a multiply is in flight.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUCnt,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t state_q, state_d;

  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   m;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             start_mul;
  logic [CW-1:0]    shamt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ill;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] q_nxt;

  assign in_ready  = (state_q == ST_IDLE);
  assign accept    = in_valid && in_ready && !flush;
  assign start_mul = accept && (ALUCnt == OP_MUL);
  assign shamt     = src_a[CW-1:0];

  always_comb begin
    sc_res = '0;
    sc_ill = 1'b0;
    case (ALUCnt)
      OP_AND: sc_res = src_a & src_b;
      OP_OR:  sc_res = src_a | src_b;
      OP_ADD: sc_res = src_a + src_b;
      OP_XOR: sc_res = src_a ^ src_b;
      OP_SLL: sc_res = src_b << shamt;
      OP_SRL: sc_res = src_b >> shamt;
      OP_SUB: sc_res = src_a - src_b;
      OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SRA: sc_res = $unsigned($signed(src_b) >>> shamt);
      OP_NOR: sc_res = ~(src_a | src_b);
      OP_MUL: sc_res = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  // One Booth step: add/subtract M per {Q[0],q_m1}, then arithmetic shift of {acc,Q,q_m1}.
  always_comb begin
    booth_sum = acc;
    case ({q[0], q_m1})
      2'b01:   booth_sum = acc + m;
      2'b10:   booth_sum = acc - m;
      default: booth_sum = acc;
    endcase
    acc_nxt = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    q_nxt   = {booth_sum[0], q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_mul) state_d = ST_MUL;
        ST_MUL:  if (cnt == LAST) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b1;
      illegal   <= 1'b0;
      acc       <= '0;
      m         <= '0;
      q         <= '0;
      q_m1      <= 1'b0;
      cnt       <= '0;
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        cnt <= '0;
      end else if (accept) begin
        if (ALUCnt == OP_MUL) begin
          acc  <= '0;
          q    <= src_b;
          q_m1 <= 1'b0;
          m    <= {src_a[WIDTH-1], src_a};
          cnt  <= '0;
        end else begin
          out_valid <= 1'b1;
          result    <= sc_res;
          result_hi <= '0;
          zero      <= (sc_res == '0);
          illegal   <= sc_ill;
        end
      end else if (state_q == ST_MUL) begin
        acc  <= acc_nxt;
        q    <= q_nxt;
        q_m1 <= q[0];
        cnt  <= cnt + 1'b1;
        // Final iteration: the product is taken from the post-shift registers.
        if (cnt == LAST) begin
          out_valid <= 1'b1;
          result    <= q_nxt;
          result_hi <= acc_nxt[WIDTH-1:0];
          zero      <= (q_nxt == '0);
          illegal   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit at WIDTH=32, plus back-to-back, flush and reset-mid-MUL sequences.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUCnt;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zero;
  logic        illegal;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUCnt(ALUCnt), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .result(result), .result_hi(result_hi), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        il;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op from idle and wait (bounded) for its completion pulse.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [31:0] hi,
                        output logic z, output logic il, output int lat, output int rdy_low);
    @(negedge clk);
    in_valid = 1'b1;
    ALUCnt   = op;
    src_a    = a;
    src_b    = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 0;
    rdy_low  = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) rdy_low++;
      @(negedge clk);
      lat++;
    end
    res = result;
    hi  = result_hi;
    z   = zero;
    il  = illegal;
    @(negedge clk);
    chk("pulse_width", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    logic [31:0] r, h;
    logic        z, il;
    int          lat, rl, k, pulses;

    vecs[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b0};
    vecs[1]  = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0};
    vecs[2]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0};
    vecs[3]  = '{4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b1, 1'b0};
    vecs[4]  = '{4'b1001, 32'h00000004, 32'h80000000, 32'hF8000000, 32'h0, 1'b0, 1'b0};
    vecs[5]  = '{4'b1001, 32'h0000001F, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0};
    vecs[6]  = '{4'b0100, 32'h0000001F, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b0};
    vecs[7]  = '{4'b0100, 32'hFFFFFFFF, 32'h00000003, 32'h80000000, 32'h0, 1'b0, 1'b0};
    vecs[8]  = '{4'b0101, 32'h0000001F, 32'h80000000, 32'h00000001, 32'h0, 1'b0, 1'b0};
    vecs[9]  = '{4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1'b0, 1'b0};
    vecs[10] = '{4'b0001, 32'h12340000, 32'h00005678, 32'h12345678, 32'h0, 1'b0, 1'b0};
    vecs[11] = '{4'b0011, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 32'h0, 1'b0, 1'b0};
    vecs[12] = '{4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0};
    vecs[13] = '{4'b1100, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 32'h0, 1'b1, 1'b0};
    vecs[14] = '{4'b1111, 32'h12345678, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b1};
    vecs[15] = '{4'b1010, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0, 1'b1, 1'b1};
    vecs[16] = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0};
    vecs[17] = '{4'b0110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0};
    vecs[18] = '{4'b1000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[19] = '{4'b1000, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b1, 1'b0};
    vecs[20] = '{4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
    vecs[21] = '{4'b1000, 32'h12345678, 32'h00000100, 32'h34567800, 32'h00000012, 1'b0, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; ALUCnt = 4'b0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result",    {32'd0, result},    64'd0);
    chk("rst_result_hi", {32'd0, result_hi}, 64'd0);
    chk("rst_zero",      {63'd0, zero},      64'd1);
    chk("rst_illegal",   {63'd0, illegal},   64'd0);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, h, z, il, lat, rl);
      chk($sformatf("v%0d_lat", i), 64'(lat), (vecs[i].op == 4'b1000) ? 64'd32 : 64'd0);
      chk($sformatf("v%0d_rdy_low", i), 64'(rl), (vecs[i].op == 4'b1000) ? 64'd32 : 64'd0);
      chk($sformatf("v%0d_result", i), {h, r}, {vecs[i].hi, vecs[i].res});
      chk($sformatf("v%0d_zero", i), {63'd0, z}, {63'd0, vecs[i].z});
      chk($sformatf("v%0d_illegal", i), {63'd0, il}, {63'd0, vecs[i].il});
    end

    // Back-to-back ADD, MUL, AND with in_valid held high throughout.
    @(negedge clk);
    in_valid = 1'b1; ALUCnt = 4'b0010; src_a = 32'd3; src_b = 32'd4;
    @(negedge clk);
    chk("b2b_add_vld", {63'd0, out_valid}, 64'd1);
    chk("b2b_add_res", {32'd0, result}, 64'd7);
    ALUCnt = 4'b1000; src_a = 32'd7; src_b = 32'hFFFFFFFD;
    @(negedge clk);
    ALUCnt = 4'b0000; src_a = 32'h000000FF; src_b = 32'h0000000F;
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_mul_lat", 64'(k), 64'd32);
    chk("b2b_mul_res", {result_hi, result}, 64'hFFFFFFFF_FFFFFFEB);
    chk("b2b_mul_rdy", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_and_vld", {63'd0, out_valid}, 64'd1);
    chk("b2b_and_res", {result_hi, result}, 64'h0000000F);
    @(negedge clk);
    chk("b2b_idle", {63'd0, out_valid}, 64'd0);

    // Flush at MUL iteration 10.
    @(negedge clk);
    in_valid = 1'b1; ALUCnt = 4'b1000; src_a = 32'd3; src_b = 32'd5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_busy", {63'd0, in_ready}, 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", {63'd0, in_ready}, 64'd1);
    chk("flush_no_vld", {63'd0, out_valid}, 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("flush_quiet", 64'(pulses), 64'd0);
    run_op(4'b0010, 32'd2, 32'd3, r, h, z, il, lat, rl);
    chk("flush_add", {h, r}, 64'd5);

    // Reset at MUL iteration 20.
    @(negedge clk);
    in_valid = 1'b1; ALUCnt = 4'b1000; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    chk("rst_mid_busy", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_mid_no_vld", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_result", {result_hi, result}, 64'd0);
    chk("rst_mid_zero", {63'd0, zero}, 64'd1);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("rst_mid_quiet", 64'(pulses), 64'd0);
    run_op(4'b0010, 32'h10, 32'h20, r, h, z, il, lat, rl);
    chk("rst_mid_add", {h, r}, 64'h30);
    chk("rst_mid_add_lat", 64'(lat), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
